// File: rtl/reg_file.sv
// reg_file -- two-read / one-write MIPS general-purpose register file.
//
// Holds 2^ADDR registers of SIZE bits. Register 0 always reads as zero and
// ignores writes. Each read port has a write-through bypass: when the
// write-back stage is writing the address being read, the new value is
// returned in the same cycle. This replaces the classic half-cycle write.
//
// Ports:
//   clk    in   1     rising-edge clock
//   rst_n  in   1     synchronous active-low reset; clears every register
//   we     in   1     write enable from write-back
//   wa     in   ADDR  write address
//   wd     in   SIZE  write data
//   ra1    in   ADDR  read address, port 1 (rs)
//   ra2    in   ADDR  read address, port 2 (rt)
//   rd1    out  SIZE  read data, port 1 (combinational)
//   rd2    out  SIZE  read data, port 2 (combinational)
module reg_file #(
  parameter int unsigned SIZE = 32,
  parameter int unsigned ADDR = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [ADDR-1:0] wa,
  input  logic [SIZE-1:0] wd,
  input  logic [ADDR-1:0] ra1,
  input  logic [ADDR-1:0] ra2,
  output logic [SIZE-1:0] rd1,
  output logic [SIZE-1:0] rd2
);

  localparam int unsigned NREG = 1 << ADDR;

  logic [SIZE-1:0] regs_q [NREG];
  logic [SIZE-1:0] regs_d [NREG];

  // A write is effective only out of reset and never to register 0.
  logic wr_active;
  assign wr_active = rst_n && we && (wa != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_active) begin
      regs_d[wa] = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Address 0 is forced to zero ahead of the bypass so a discarded write to
  // r0 can never leak through to a read port.
  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      if (wr_active && (ra1 == wa)) begin
        rd1 = wd;
      end else begin
        rd1 = regs_q[ra1];
      end
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      if (wr_active && (ra2 == wa)) begin
        rd2 = wd;
      end else begin
        rd2 = regs_q[ra2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file -- self-checking bench for reg_file: directed scenarios
// followed by randomized traffic compared against an array reference model.
module tb_reg_file;

  localparam int unsigned SIZE = 32;
  localparam int unsigned ADDR = 5;
  localparam int unsigned NREG = 1 << ADDR;

  logic            clk;
  logic            rst_n;
  logic            we;
  logic [ADDR-1:0] wa;
  logic [SIZE-1:0] wd;
  logic [ADDR-1:0] ra1;
  logic [ADDR-1:0] ra2;
  logic [SIZE-1:0] rd1;
  logic [SIZE-1:0] rd2;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [SIZE-1:0] model [NREG];

  reg_file #(
    .SIZE(SIZE),
    .ADDR(ADDR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .ra1  (ra1),
    .ra2  (ra2),
    .rd1  (rd1),
    .rd2  (rd2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [SIZE-1:0] got,
                           input logic [SIZE-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected read value straight from the behavioural rules.
  function automatic logic [SIZE-1:0] predict(input logic [ADDR-1:0] ra);
    if (ra == 0) return '0;
    if (rst_n && we && wa != 0 && wa == ra) return wd;
    return model[ra];
  endfunction

  // Apply one rising edge to both the model and the DUT, then settle.
  task automatic step();
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) model[i] = '0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [ADDR-1:0] a,
                       input logic [SIZE-1:0] d, input logic [ADDR-1:0] a1,
                       input logic [ADDR-1:0] a2);
    rst_n = r; we = w; wa = a; wd = d; ra1 = a1; ra2 = a2;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < NREG; i++) model[i] = 'x;

    @(posedge clk);
    #1;
    // Initial reset.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();

    // Reset clears a preloaded register.
    drive(1'b1, 1'b1, 5'd5, 32'h1234_5678, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check_val("preload_r5", rd1, 32'h1234_5678);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    step();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check_val("reset_r5", rd1, 32'h0);
    for (int i = 0; i < NREG; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(NREG - 1 - i));
      check_val("reset_sweep_rd1", rd1, 32'h0);
      check_val("reset_sweep_rd2", rd2, 32'h0);
    end

    // Basic write/read.
    drive(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b1, 5'd8, 32'h0000_00FF, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8);
    check_val("basic_r7", rd1, 32'hDEAD_BEEF);
    check_val("basic_r8", rd2, 32'h0000_00FF);

    // r0 hardwired.
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    check_val("r0_same_rd1", rd1, 32'h0);
    check_val("r0_same_rd2", rd2, 32'h0);
    step();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check_val("r0_after_rd1", rd1, 32'h0);
    check_val("r0_after_rd2", rd2, 32'h0);
    step();
    check_val("r0_later_rd1", rd1, 32'h0);

    // Bypass on both ports.
    drive(1'b1, 1'b1, 5'd3, 32'h1111_1111, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b1, 5'd3, 32'h2222_2222, 5'd3, 5'd3);
    check_val("bypass_rd1", rd1, 32'h2222_2222);
    check_val("bypass_rd2", rd2, 32'h2222_2222);
    step();
    drive(1'b1, 1'b0, 5'd3, 32'h0, 5'd3, 5'd3);
    check_val("bypass_held_rd1", rd1, 32'h2222_2222);
    check_val("bypass_held_rd2", rd2, 32'h2222_2222);

    // Bypass suppressed during reset; write lost.
    drive(1'b0, 1'b1, 5'd3, 32'h3333_3333, 5'd3, 5'd3);
    check_val("rst_bypass_off", 32'(rd1 != 32'h3333_3333), 32'h1);
    check_val("rst_bypass_array", rd1, 32'h2222_2222);
    step();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check_val("rst_write_lost", rd1, 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      logic            r;
      logic            w;
      logic [ADDR-1:0] a;
      logic [ADDR-1:0] a1;
      logic [ADDR-1:0] a2;
      r  = ($urandom_range(0, 99) != 0);
      w  = 1'($urandom);
      a  = ADDR'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? a : ADDR'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? a : ADDR'($urandom);
      drive(r, w, a, SIZE'($urandom), a1, a2);
      check_val("rand_rd1", rd1, predict(ra1));
      check_val("rand_rd2", rd2, predict(ra2));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
